// File: rtl/avg_pkg.sv
// Shared types for the triple collector and the downstream averaging pipeline.
package avg_pkg;

  localparam int LANES    = 3;
  localparam int SAMPLE_W = 8;

  typedef logic [SAMPLE_W-1:0] sample_t;

  typedef enum logic [1:0] {
    COL0 = 2'd0,
    COL1 = 2'd1,
    COL2 = 2'd2,
    PEND = 2'd3
  } state_t;

endpackage

// File: rtl/triple_out_reg.sv
// Output slot: holds the presented triple, its valid flag and the handoff counter.
module triple_out_reg
  import avg_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       i_load,
  input  logic [7:0] i_a,
  input  logic [7:0] i_b,
  input  logic [7:0] i_c,
  input  logic       i_outReady,
  output logic [7:0] o_a,
  output logic [7:0] o_b,
  output logic [7:0] o_c,
  output logic       o_valid,
  output logic [7:0] o_cnt
);

  sample_t r_a;
  sample_t r_b;
  sample_t r_c;
  logic    r_valid;
  sample_t r_cnt;
  logic    w_handoff;

  assign w_handoff = r_valid && i_outReady;

  // A load in the same cycle as a handoff keeps valid high with the new triple.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_c     <= '0;
      r_valid <= 1'b0;
      r_cnt   <= '0;
    end else begin
      if (i_load) begin
        r_a     <= i_a;
        r_b     <= i_b;
        r_c     <= i_c;
        r_valid <= 1'b1;
      end else if (w_handoff) begin
        r_valid <= 1'b0;
      end
      if (w_handoff) begin
        r_cnt <= r_cnt + 8'd1;
      end
    end
  end

  assign o_a     = r_a;
  assign o_b     = r_b;
  assign o_c     = r_c;
  assign o_valid = r_valid;
  assign o_cnt   = r_cnt;

endmodule

// File: rtl/triple_collector.sv
// Gathers three consecutive samples into a triple and presents it to the averaging stage.
module triple_collector
  import avg_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       flush,
  output logic [7:0] a,
  output logic [7:0] b,
  output logic [7:0] c,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] triple_cnt
);

  state_t  r_state;
  sample_t r_col [LANES];

  logic    w_accept;
  logic    w_handoff;
  logic    w_slotFree;
  logic    w_load;
  sample_t w_loadA;
  sample_t w_loadB;
  sample_t w_loadC;

  assign in_ready   = !flush && (r_state != PEND);
  assign w_accept   = in_valid && in_ready;
  assign w_handoff  = out_valid && out_ready;
  assign w_slotFree = !out_valid || out_ready;

  // The third sample bypasses r_col[2] when the slot can take it immediately.
  always_comb begin
    w_load  = 1'b0;
    w_loadA = r_col[0];
    w_loadB = r_col[1];
    w_loadC = r_col[2];
    case (r_state)
      COL2: begin
        if (w_accept && w_slotFree) begin
          w_load  = 1'b1;
          w_loadC = in_data;
        end
      end
      PEND: begin
        if (w_handoff) begin
          w_load = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= COL0;
      for (int i = 0; i < LANES; i++) begin
        r_col[i] <= '0;
      end
    end else begin
      case (r_state)
        COL0: begin
          if (w_accept) begin
            r_col[0] <= in_data;
            r_state  <= COL1;
          end
        end
        COL1: begin
          if (flush) begin
            r_state <= COL0;
          end else if (w_accept) begin
            r_col[1] <= in_data;
            r_state  <= COL2;
          end
        end
        COL2: begin
          if (flush) begin
            r_state <= COL0;
          end else if (w_accept) begin
            if (w_slotFree) begin
              r_state <= COL0;
            end else begin
              r_col[2] <= in_data;
              r_state  <= PEND;
            end
          end
        end
        PEND: begin
          if (w_handoff) begin
            r_state <= COL0;
          end
        end
      endcase
    end
  end

  triple_out_reg u_outReg (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_load),
    .i_a        (w_loadA),
    .i_b        (w_loadB),
    .i_c        (w_loadC),
    .i_outReady (out_ready),
    .o_a        (a),
    .o_b        (b),
    .o_c        (c),
    .o_valid    (out_valid),
    .o_cnt      (triple_cnt)
  );

endmodule

// File: doc/triple_collector.md
TRIPLE_COLLECTOR -- requirements
Module: triple_collector

Interface
REQ-001 SHALL be clocked by a single clock; reset is synchronous and active-high.
REQ-002 Port: clk  input  1  rising-edge clock for all state.
REQ-003 Port: rst  input  1  synchronous, active-high reset.
REQ-004 Port: in_data  input  8  unsigned sample byte from the serial source.
REQ-005 Port: in_valid  input  1  in_data is valid this cycle.
REQ-006 Port: in_ready  output  1  block accepts in_data this cycle.
REQ-007 Port: flush  input  1  discard any partially collected triple.
REQ-008 Port: a  output  8  first sample of the presented triple.
REQ-009 Port: b  output  8  second sample of the presented triple.
REQ-010 Port: c  output  8  third sample of the presented triple.
REQ-011 Port: out_valid  output  1  a/b/c hold a complete triple.
REQ-012 Port: out_ready  input  1  downstream three-stage averaging pipeline consumes a/b/c; tied high when the consumer never stalls.
REQ-013 Port: triple_cnt  output  8  count of triples handed off, wraps modulo 256.

Function
REQ-014 SHALL define an input accept as in_valid && in_ready, and an output handoff as out_valid && out_ready.
REQ-015 SHALL implement the FSM states COL0, COL1, COL2 and PEND, where COL0/COL1/COL2 wait for sample 0/1/2 and PEND holds a full triple blocked on output.
REQ-016 SHALL drive in_ready = !flush && (state != PEND), combinationally.
REQ-017 SHALL capture an accept in COL0 into r0 and go to COL1, and capture an accept in COL1 into r1 and go to COL2.
REQ-018 SHALL, on an accept in COL2 with the output slot free or handing off in the same cycle, load a=r0, b=r1, c=in_data, set out_valid, and go to COL0.
REQ-019 SHALL, on an accept in COL2 with the output slot occupied and not handing off, store in_data into r2 and go to PEND.
REQ-020 SHALL, in PEND on an output handoff, load a/b/c from r0/r1/r2, keep out_valid at 1, and go to COL0 in the same cycle.
REQ-021 SHALL assert out_valid on the cycle after the third accept when the output is unblocked (latency 1).
REQ-022 SHALL clear out_valid on a handoff unless a new triple loads in the same cycle.
REQ-023 SHALL hold a/b/c and out_valid stable while out_valid && !out_ready.
REQ-024 SHALL, when flush is high in COL1 or COL2, return to COL0 with no accept that cycle.
REQ-025 SHALL ignore flush in PEND and in the output slot, so a complete triple is never discarded.
REQ-026 SHALL increment triple_cnt by 1 on every output handoff, wrapping 255 -> 0.
REQ-027 SHALL pass samples through unmodified with no arithmetic; averaging belongs to the downstream stage.
REQ-028 SHALL leave a/b/c unchanged when no triple loads.

Reset
REQ-029 SHALL, with rst high at a clock edge, set state=COL0, out_valid=0, a=b=c=0, r0=r1=r2=0 and triple_cnt=0.
REQ-030 SHALL give rst priority over flush, accepts and handoffs, and SHALL discard any partial or pending triple.
REQ-031 SHALL drive in_ready at 0 only through flush or PEND; the cycle after reset is released, in_ready=1.

Structure
REQ-032 SHALL place the 8-bit sample typedef, the FSM state enum and a LANES=3 constant in shared package avg_pkg, reused by the averaging pipeline.
REQ-033 SHALL keep the output slot (a/b/c, out_valid, handoff logic) in one sub-module, triple_out_reg; the FSM and collection registers stay in the top level.

Verification
REQ-034 Bench SHALL cover: out_ready=1, feed 3,6,9 on consecutive cycles -> a=3, b=6, c=9 with out_valid=1 one cycle after the 9 is accepted, and triple_cnt=1 after the handoff.
REQ-035 Bench SHALL cover: out_ready=0, feed 3,6,9,4,8,12 -> in_ready=0 after the 12 is accepted (PEND); raise out_ready -> handoff of 3,6,9, then a/b/c=4,8,12 on the next cycle, then in_ready=1.
REQ-036 Bench SHALL cover: feed 5,7, pulse flush, feed 1,2,3 -> next triple presented is 1,2,3, and 5/7 never appear at the output.
REQ-037 Bench SHALL cover: output occupied and the third sample accepted in the same cycle as the handoff -> new triple loaded with out_valid continuously 1 and no PEND entry.
REQ-038 Bench SHALL cover: rst asserted in COL2 with out_valid=1 -> next cycle out_valid=0, a=b=c=0, triple_cnt=0, state=COL0.
REQ-039 Bench SHALL cover: 256 handoffs -> triple_cnt wraps from 255 to 0.
